// File: rtl/display_timing.sv
// display_timing: progressive/interlaced raster timing generator with pipelined,
// registered video output aligned to the composer's display_data latency.
module display_timing #(
  parameter int PIPE_DELAY = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interlaced,
  input  logic [7:0] display_data,
  output logic       display_next_frame,
  output logic       display_next_line,
  output logic       display_next_pixel,
  output logic       display_current_field,
  output logic [7:0] video_data,
  output logic       video_de,
  output logic       hsync_n,
  output logic       vsync_n
);
  localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  logic [10:0] r_h, w_ht, w_hact, w_hs0, w_hs1;
  logic [9:0] r_v, w_vt, w_vact, w_vs0, w_vs1;
  logic r_mode, r_field, w_hs, w_vs;
  logic [PIPE_DELAY-1:0] r_de, r_hsd, r_vsd;
  // interlaced mode doubles every horizontal parameter; field 0 carries the odd extra line
  always_comb begin
    w_ht   = r_mode ? 11'(2 * HT) : 11'(HT);
    w_hact = r_mode ? 11'(2 * H_ACTIVE) : 11'(H_ACTIVE);
    w_hs0  = r_mode ? 11'(2 * (H_ACTIVE + H_FRONT)) : 11'(H_ACTIVE + H_FRONT);
    w_hs1  = r_mode ? 11'(2 * (H_ACTIVE + H_FRONT + H_SYNC)) : 11'(H_ACTIVE + H_FRONT + H_SYNC);
    w_vt   = r_mode ? (r_field ? 10'd262 : 10'd263) : 10'(VT);
    w_vact = r_mode ? 10'd240 : 10'(V_ACTIVE);
    w_vs0  = r_mode ? 10'd244 : 10'(V_ACTIVE + V_FRONT);
    w_vs1  = r_mode ? 10'd247 : 10'(V_ACTIVE + V_FRONT + V_SYNC);
  end
  assign display_next_line     = r_h == w_ht - 11'd1;
  assign display_next_frame    = display_next_line && r_v == w_vt - 10'd1;
  assign display_next_pixel    = r_h < w_hact && r_v < w_vact;
  assign display_current_field = r_field;
  assign w_hs = r_h >= w_hs0 && r_h < w_hs1;
  assign w_vs = r_v >= w_vs0 && r_v < w_vs1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_h        <= '0;
      r_v        <= '0;
      r_mode     <= 1'b0;
      r_field    <= 1'b0;
      r_de       <= '0;
      r_hsd      <= '0;
      r_vsd      <= '0;
      video_data <= '0;
      video_de   <= 1'b0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
    end else begin
      r_h <= display_next_line ? '0 : r_h + 11'd1;
      r_v <= display_next_frame ? '0 : display_next_line ? r_v + 10'd1 : r_v;
      if (display_next_frame) begin
        r_mode  <= interlaced;
        r_field <= r_mode & interlaced & ~r_field;
      end
      r_de       <= (r_de << 1) | PIPE_DELAY'(display_next_pixel);
      r_hsd      <= (r_hsd << 1) | PIPE_DELAY'(w_hs);
      r_vsd      <= (r_vsd << 1) | PIPE_DELAY'(w_vs);
      video_de   <= r_de[PIPE_DELAY-1];
      video_data <= r_de[PIPE_DELAY-1] ? display_data : '0;
      hsync_n    <= ~r_hsd[PIPE_DELAY-1];
      vsync_n    <= ~r_vsd[PIPE_DELAY-1];
    end
endmodule
